// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    DEV_W,
    ACK1,
    MEM_ADR,
    ACK2,
    WDATA,
    WACK,
    RSTART,
    DEV_R,
    ACK3,
    RDATA,
    MACK,
    STOP
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase generator: each quarter lasts PRESCALE+1 clocks, q cycles 0..3.
// en low parks the generator at the start of Q0; hold freezes it in place.
module i2c_phase_gen #(
  parameter int PRESCALE = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       hold,
  output logic [1:0] q,
  output logic       q_last
);

  localparam int CW = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    q_q, q_d;

  assign q      = q_q;
  assign q_last = !hold && (cnt_q == CW'(PRESCALE));

  // Next prescaler count and quarter index.
  always_comb begin
    cnt_d = cnt_q;
    q_d   = q_q;
    if (!en) begin
      cnt_d = '0;
      q_d   = 2'd0;
    end else if (!hold) begin
      if (cnt_q == CW'(PRESCALE)) begin
        cnt_d = '0;
        q_d   = q_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescaler and quarter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// I2C master that runs one register-addressed read or write transaction per command.
module i2c_txn_sequencer #(
  parameter int PRESCALE = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev_adr,
  input  logic [7:0] cmd_mem_adr,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       scl_oen,
  output logic       sda_oen,
  input  logic       sda_i
);

  import i2c_pkg::*;

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  rx_q, rx_d;
  logic        ack_q, ack_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  mem_q, mem_d;
  logic        loaded_q, loaded_d;
  logic        nack_q, nack_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        done_pend_q, done_pend_d;

  logic [1:0]  q;
  logic        q_last;
  logic        pg_en;
  logic        pg_hold;
  logic        bit_end;
  logic        smp;

  assign bit_end = q_last && (q == 2'd3);
  assign smp     = q_last && (q == 2'd2);

  // The repeated START drops en on the last cycle of its lead-in quarter so the
  // START pattern that follows begins again at Q0.
  assign pg_en   = (state_q != IDLE) && !((state_q == RSTART) && (bit_q == 3'd0) && q_last);
  assign pg_hold = (state_q == WDATA) && !loaded_q && !wr_valid;

  assign cmd_ready = (state_q == IDLE) && !done_pend_q && !done_q;
  assign busy      = !cmd_ready;
  assign wr_ready  = (state_q == WDATA) && !loaded_q && wr_valid;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign nack_err  = nack_q;

  i2c_phase_gen #(.PRESCALE(PRESCALE)) u_phase (
    .clk    (clk),
    .rst    (rst),
    .en     (pg_en),
    .hold   (pg_hold),
    .q      (q),
    .q_last (q_last)
  );

  // Transaction sequencing: next state, shift registers, byte counter, status.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    mem_d       = mem_q;
    loaded_d    = loaded_q;
    nack_d      = nack_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    done_pend_d = done_pend_q;

    if (smp) ack_d = sda_i;

    // done follows the first fully idle cycle after STOP releases SDA.
    if (done_pend_q) begin
      done_pend_d = 1'b0;
      done_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d  = START;
          rw_d     = cmd_rw;
          dev_d    = cmd_dev_adr;
          mem_d    = cmd_mem_adr;
          cnt_d    = (cmd_len == 4'd0) ? 4'd1 : cmd_len;
          nack_d   = 1'b0;
          loaded_d = 1'b0;
          bit_d    = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DEV_W;
          tx_d    = {dev_q, RW_WRITE};
          bit_d   = 3'd0;
        end
      end
      RSTART: begin
        if (bit_q == 3'd0) begin
          if (q_last) bit_d = 3'd1;
        end else if (bit_end) begin
          state_d = DEV_R;
          tx_d    = {dev_q, RW_READ};
          bit_d   = 3'd0;
        end
      end
      DEV_W, MEM_ADR, DEV_R, WDATA: begin
        if ((state_q == WDATA) && !loaded_q && wr_valid) begin
          tx_d     = wr_data;
          loaded_d = 1'b1;
        end
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            case (state_q)
              DEV_W:   state_d = ACK1;
              MEM_ADR: state_d = ACK2;
              DEV_R:   state_d = ACK3;
              default: begin
                state_d  = WACK;
                loaded_d = 1'b0;
              end
            endcase
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end
        end
      end
      ACK1, ACK2, ACK3, WACK: begin
        if (bit_end) begin
          bit_d = 3'd0;
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else begin
            case (state_q)
              ACK1: begin
                state_d = MEM_ADR;
                tx_d    = mem_q;
              end
              ACK2:    state_d = (rw_q == RW_READ) ? RSTART : WDATA;
              ACK3:    state_d = RDATA;
              default: begin
                if (cnt_q == 4'd1) begin
                  state_d = STOP;
                end else begin
                  cnt_d   = cnt_q - 4'd1;
                  state_d = WDATA;
                end
              end
            endcase
          end
        end
      end
      RDATA: begin
        if (smp) begin
          rx_d = {rx_q[5:0], sda_i};
          if (bit_q == 3'd7) begin
            rd_data_d  = {rx_q, sda_i};
            rd_valid_d = 1'b1;
          end
        end
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = MACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      MACK: begin
        if (bit_end) begin
          bit_d = 3'd0;
          if (cnt_q == 4'd1) begin
            state_d = STOP;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = RDATA;
          end
        end
      end
      STOP: begin
        if (q_last && (q == 2'd2)) begin
          state_d     = IDLE;
          done_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus line decode; SCL is low in Q0/Q1 and released in Q2/Q3 of each bit.
  // While WDATA waits for a byte SDA stays released and only settles once the
  // byte arrives, still within the SCL-low half of the bit.
  always_comb begin
    scl_oen = 1'b1;
    sda_oen = 1'b1;
    case (state_q)
      START:  sda_oen = !q[1];
      RSTART: begin
        if (bit_q == 3'd0) scl_oen = 1'b0;
        else               sda_oen = !q[1];
      end
      DEV_W, MEM_ADR, DEV_R: begin
        scl_oen = q[1];
        sda_oen = tx_q[7];
      end
      WDATA: begin
        scl_oen = q[1];
        sda_oen = loaded_q ? tx_q[7] : 1'b1;
      end
      ACK1, ACK2, ACK3, WACK, RDATA: scl_oen = q[1];
      MACK: begin
        scl_oen = q[1];
        sda_oen = (cnt_q == 4'd1);
      end
      STOP: begin
        scl_oen = (q != 2'd0);
        sda_oen = (q == 2'd2);
      end
      default: begin
        scl_oen = 1'b1;
        sda_oen = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_q       <= 3'd0;
      tx_q        <= 8'd0;
      rx_q        <= 7'd0;
      ack_q       <= 1'b0;
      cnt_q       <= 4'd0;
      rw_q        <= RW_WRITE;
      dev_q       <= 7'd0;
      mem_q       <= 8'd0;
      loaded_q    <= 1'b0;
      nack_q      <= 1'b0;
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      mem_q       <= mem_d;
      loaded_q    <= loaded_d;
      nack_q      <= nack_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      done_pend_q <= done_pend_d;
    end
  end

endmodule

// File: doc/i2c_txn_sequencer.md
I2C_TXN_SEQUENCER -- requirements
Module: i2c_txn_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 24; each SCL quarter-phase lasts PRESCALE+1 clk cycles.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  1 = read, 0 = write
- cmd_dev_adr  in  7  target device address
- cmd_mem_adr  in  8  register/memory address byte
- cmd_len  in  4  data bytes to transfer; 0 treated as 1
- wr_data  in  8  write byte
- wr_valid  in  1  write byte offered
- wr_ready  out  1  1-cycle pulse when wr_data is consumed
- rd_data  out  8  received byte
- rd_valid  out  1  1-cycle pulse, no backpressure
- busy  out  1  command in progress
- done  out  1  1-cycle pulse after STOP completes
- nack_err  out  1  sticky; set on unexpected NACK, cleared on next accepted command
- scl_oen  out  1  0 drives SCL low, 1 releases
- sda_oen  out  1  0 drives SDA low, 1 releases
- sda_i  in  1  sampled bus SDA

Function
REQ-003 SHALL accept a command on clk when cmd_valid && cmd_ready, latching all cmd_* fields.
REQ-004 SHALL split each bit into four quarter-phases Q0..Q3: SCL low in Q0/Q1, released in Q2/Q3; SDA changes only at Q0 entry; sda_i sampled on the last cycle of Q2.
REQ-005 START: SDA released, SCL released for two quarters, then SDA low for two quarters, then SCL low; repeated START is identical, preceded by one SCL-low quarter with SDA released.
REQ-006 STOP: SDA low with SCL low for one quarter, SCL released for one quarter, then SDA released; done pulses one cycle after SDA release.
REQ-007 States: IDLE, START, DEV_W, ACK1, MEM_ADR, ACK2, WDATA, WACK, RSTART, DEV_R, ACK3, RDATA, MACK, STOP.
REQ-008 Write sequence: START, DEV_W ({dev_adr,0}, MSB first), ACK1, MEM_ADR, ACK2, then cmd_len x (WDATA, WACK), then STOP.
REQ-009 Read sequence: START, DEV_W, ACK1, MEM_ADR, ACK2, RSTART, DEV_R ({dev_adr,1}), ACK3, then cmd_len x (RDATA, MACK), then STOP.
REQ-010 MACK SHALL drive ACK (SDA low) on every byte except the last, and NACK (SDA released) on the last.
REQ-011 rd_data/rd_valid SHALL update on the cycle after the eighth RDATA sample.
REQ-012 wr_ready SHALL pulse at WDATA entry when wr_valid is high; if wr_valid is low, the sequencer SHALL hold Q0 (SCL low) until wr_valid is high.
REQ-013 On a NACK (sda_i=1) in ACK1, ACK2, ACK3 or WACK, the sequencer SHALL set nack_err, abandon remaining bytes, go to STOP, and still pulse done.
REQ-014 A byte counter SHALL count remaining bytes; the last byte is detected at count==1, with no wrap.
REQ-015 busy SHALL be high from acceptance through the done cycle; cmd_valid while busy SHALL be ignored.

Reset
REQ-016 While rst is high, the block SHALL be in IDLE with scl_oen=1, sda_oen=1, cmd_ready=1, busy=0, done=0, rd_valid=0, wr_ready=0, nack_err=0, rd_data=0, and all counters cleared.
REQ-017 A reset mid-transaction SHALL release both lines immediately (asynchronously) and generate no STOP.

Structure
REQ-018 A shared package i2c_pkg SHALL hold the state enumeration and the RW_READ/RW_WRITE constants.
REQ-019 The quarter-phase prescaler/phase counter SHALL be the sub-module i2c_phase_gen (in: clk, rst, en, hold; out: q[1:0], q_last).

Verification
REQ-020 Write: dev 0x10, mem 0x01, len 2, data 0xA5,0x5A -> bus model slave stores mem[1]=A5, mem[2]=5A; done=1, nack_err=0.
REQ-021 Read: dev 0x10, mem 0x01, len 2 after REQ-020 -> rd_data A5 then 5A; second MACK is NACK; a repeated START is observed.
REQ-022 Wrong device: dev 0x11 -> ACK1 NACK, nack_err=1, STOP on bus, done pulse, zero wr_ready pulses.
REQ-023 Invalid mem address 0x20 -> ACK2 NACK, nack_err=1, STOP; the next valid command clears nack_err.
REQ-024 Write len 1 with wr_valid withheld 500 cycles -> SCL held low throughout, then the transfer completes correctly.
REQ-025 rst asserted during RDATA -> scl_oen=sda_oen=1 in the same cycle; after reset release, cmd_ready=1.
